// File: rtl/pipelined_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake on both sides.
// WIDTH bits are split into STAGES slices of 4-bit CLA groups; inter-slice carries are registered.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SW     = int'(WIDTH / STAGES);
  localparam int Groups = SW / 4;

  if ((STAGES < 1) || (WIDTH % (4 * STAGES) != 0)) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of 4*STAGES");
  end

  // Returns {group carry-out, 4-bit sum}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] g, p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Groups ripple group-to-group; returns {slice carry-out, slice sum}.
  function automatic logic [SW:0] slice_add(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                            input logic ci);
    logic [SW-1:0] s;
    logic          c;
    logic [4:0]    r;
    s = '0;
    c = ci;
    for (int i = 0; i < Groups; i++) begin
      r          = cla4(x[4*i +: 4], y[4*i +: 4], c);
      s[4*i +: 4] = r[3:0];
      c          = r[4];
    end
    return {c, s};
  endfunction

  logic [WIDTH-1:0]  b_cond;
  logic              c0;
  logic [STAGES-1:0] slice_v;
  logic [STAGES:0]   take;

  assign b_cond = op[0] ? ~b : b;
  assign c0     = op[1] ? carry_in : op[0];

  always_comb begin
    take[STAGES] = !out_valid || out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      take[k] = !slice_v[k] || take[k+1];
    end
  end

  assign in_ready = take[0];

  // Slice register k: x_q holds finished sum bits below slice k and raw A above,
  // y_q holds the still-unprocessed conditioned B bits, c_q the carry into slice k.
  for (genvar k = 0; k < int'(STAGES); k++) begin : g_slice
    localparam int YW = int'(WIDTH) - k * SW;

    logic [WIDTH-1:0] x_d, x_q;
    logic [YW-1:0]    y_d, y_q;
    logic             c_d, c_q, v_d, v_q;
    logic [SW:0]      res;

    if (k == 0) begin : g_head
      assign x_d = a;
      assign y_d = b_cond;
      assign c_d = c0;
      assign v_d = in_valid;
    end else begin : g_body
      always_comb begin
        x_d = g_slice[k-1].x_q;
        x_d[(k-1)*SW +: SW] = g_slice[k-1].res[SW-1:0];
      end
      assign y_d = g_slice[k-1].y_q[YW+SW-1:SW];
      assign c_d = g_slice[k-1].res[SW];
      assign v_d = g_slice[k-1].v_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        x_q <= '0;
        y_q <= '0;
        c_q <= 1'b0;
      end else if (take[k]) begin
        v_q <= v_d;
        if (v_d) begin
          x_q <= x_d;
          y_q <= y_d;
          c_q <= c_d;
        end
      end
    end

    assign res        = slice_add(x_q[k*SW +: SW], y_q[SW-1:0], c_q);
    assign slice_v[k] = v_q;
  end

  logic [WIDTH-1:0] fin_sum;
  logic             fin_cout, fin_ovf;

  // Carry into the MSB is recovered from sum ^ a ^ b' at the top bit.
  always_comb begin
    fin_sum = g_slice[STAGES-1].x_q;
    fin_sum[(STAGES-1)*SW +: SW] = g_slice[STAGES-1].res[SW-1:0];
    fin_cout = g_slice[STAGES-1].res[SW];
    fin_ovf  = fin_sum[WIDTH-1] ^ g_slice[STAGES-1].x_q[WIDTH-1]
             ^ g_slice[STAGES-1].y_q[SW-1] ^ fin_cout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else if (take[STAGES]) begin
      out_valid <= slice_v[STAGES-1];
      if (slice_v[STAGES-1]) begin
        sum  <= fin_sum;
        cout <= fin_cout;
        ovf  <= fin_ovf;
        zero <= (fin_sum == '0);
        neg  <= fin_sum[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed vector table, 64-bit chain,
// streaming with backpressure, full-pipeline stall and mid-stream reset.
module tb_pipelined_addsub;
  localparam int W = 32;
  localparam int S = 2;

  typedef logic [W+3:0] res_t;  // {sum, cout, ovf, zero, neg}

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         carry_in = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   op = 2'b00;
  logic         in_ready, out_valid, cout, ovf, zero, neg;
  logic [W-1:0] sum;
  res_t         dut_res;

  int checks = 0;
  int failures = 0;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .carry_in(carry_in), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;
  assign dut_res = {sum, cout, ovf, zero, neg};

  function automatic res_t model(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y, logic ci);
    logic [W-1:0] yy;
    logic         cc;
    logic [W:0]   t;
    yy = o[0] ? ~y : y;
    cc = o[1] ? ci : o[0];
    t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
    return {t[W-1:0], t[W], (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]), t[W-1:0] == '0,
            t[W-1]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single op with out_ready=1; checks the result appears exactly S edges after accept.
  task automatic run_one(input string name, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic ci, output res_t r);
    op = o; a = x; b = y; carry_in = ci; in_valid = 1'b1; out_ready = 1'b1;
    check({name, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < S; i++) begin
      check({name, "_early_valid"}, out_valid, 0);
      tick();
    end
    check({name, "_latency"}, out_valid, 1);
    r = dut_res;
    tick();
  endtask

  task automatic run_stream(input string name, input int n, input bit rnd_ready,
                            input bit rnd_valid, output int cyc);
    res_t q[$];
    res_t held;
    int   sent = 0, got = 0;
    bit   stalled = 0, in_fire, out_fire;
    cyc = 0;
    op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom; carry_in = 1'($urandom);
    in_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
    out_ready = rnd_ready ? 1'($urandom) : 1'b1;
    while ((sent < n || q.size() > 0) && cyc < 2000) begin
      @(negedge clk);
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (stalled) check({name, "_stall_hold"}, {out_valid, dut_res}, {1'b1, held});
      stalled = out_valid && !out_ready;
      held    = dut_res;
      if (out_fire) begin
        if (q.size() == 0) check({name, "_extra_result"}, 1, 0);
        else check({name, "_result"}, dut_res, q.pop_front());
        got++;
      end
      if (in_fire) begin
        q.push_back(model(op, a, b, carry_in));
        sent++;
      end
      tick();
      cyc++;
      if (!(in_valid && !in_fire)) begin
        op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom; carry_in = 1'($urandom);
        in_valid = (sent < n) && (rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
      out_ready = rnd_ready ? 1'($urandom) : 1'b1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({name, "_counts"}, {32'(sent), 32'(got)}, {32'(n), 32'(n)});
  endtask

  vec_t vecs[14];

  initial begin
    res_t r, lo, hi;
    int   cyc, acc;
    res_t q5[$];

    vecs[0]  = '{"add_wrap",    2'b00, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1, 0, 1, 0};
    vecs[1]  = '{"sub_ovf",     2'b01, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1, 1, 0, 0};
    vecs[2]  = '{"sub_borrow",  2'b01, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 0, 0, 0, 1};
    vecs[3]  = '{"add_povf",    2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 0, 1, 0, 1};
    vecs[4]  = '{"adc_cin",     2'b10, 32'h0000FFFF, 32'h00000001, 1'b1, 32'h00010001, 0, 0, 0, 0};
    vecs[5]  = '{"sbb_borrow",  2'b11, 32'h00000005, 32'h00000003, 1'b0, 32'h00000001, 1, 0, 0, 0};
    vecs[6]  = '{"sbb_zero",    2'b11, 32'h00000000, 32'h00000000, 1'b0, 32'hFFFFFFFF, 0, 0, 0, 1};
    vecs[7]  = '{"add_mixed",   2'b00, 32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 0, 0, 0, 1};
    vecs[8]  = '{"sub_equal",   2'b01, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1, 0, 1, 0};
    vecs[9]  = '{"adc_wrap",    2'b10, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1, 0, 1, 0};
    vecs[10] = '{"add_novf",    2'b00, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1, 1, 1, 0};
    vecs[11] = '{"sub_negb",    2'b01, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 0, 1, 0, 1};
    vecs[12] = '{"add_slice",   2'b00, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 0, 0, 0, 0};
    vecs[13] = '{"add_ignore",  2'b00, 32'h00000001, 32'h00000001, 1'b1, 32'h00000002, 0, 0, 0, 0};

    #12;
    check("reset_outputs", {in_ready, out_valid, dut_res}, {1'b1, 1'b0, 36'd0});
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", in_ready, 1);

    for (int i = 0; i < 14; i++) begin
      run_one(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, r);
      check(vecs[i].name, r, {vecs[i].s, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n});
    end

    // 64-bit chain: 0x00000000_FFFFFFFF + 1, then subtract 1 back.
    run_one("chain_add_lo", 2'b10, 32'hFFFFFFFF, 32'h00000001, 1'b0, lo);
    run_one("chain_add_hi", 2'b10, 32'h00000000, 32'h00000000, lo[3], hi);
    check("chain_add64", {hi[W+3:4], lo[W+3:4]}, 64'h00000001_00000000);
    run_one("chain_sub_lo", 2'b11, 32'h00000000, 32'h00000001, 1'b1, lo);
    run_one("chain_sub_hi", 2'b11, 32'h00000001, 32'h00000000, lo[3], hi);
    check("chain_sub64", {hi[W+3:4], lo[W+3:4]}, 64'h00000000_FFFFFFFF);

    run_stream("stream_full", 100, 1'b0, 1'b0, cyc);
    check("throughput", cyc <= 100 + S + 1, 1);
    run_stream("stream_bp", 100, 1'b1, 1'b1, cyc);

    // Fill the pipeline against a stalled consumer.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc = 0;
    op = 2'b00; a = 32'h100; b = 32'h1; carry_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        q5.push_back(model(op, a, b, carry_in));
        acc++;
        tick();
        op = 2'(i % 4); a = a + 32'h11111111; b = b + 32'h3; carry_in = ~carry_in;
      end else tick();
    end
    check("full_accepts", acc, S + 1);
    check("full_in_ready", in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q5.size() > 0; i++) begin
      @(negedge clk);
      if (out_valid) check("full_drain", dut_res, q5.pop_front());
      tick();
    end
    check("full_drained", q5.size(), 0);

    // Reset with ops in flight and a result on the output.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op = 2'b00; a = 32'h00000007; b = 32'h00000001;
    for (int i = 0; i < S + 1; i++) tick();
    check("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset", {out_valid, dut_res}, {1'b0, 36'd0});
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_rel", in_ready, 1);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) acc++;
    end
    check("no_stale_result", acc, 0);
    run_one("post_reset", 2'b01, 32'h00000010, 32'h00000001, 1'b0, r);
    check("post_reset_res", r, {32'h0000000F, 1'b1, 1'b0, 1'b0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule
